game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
// - Top-level game sequencer for flappy. Owns the one-hot game state consumed by the pillar and bird stages.
// - Consumes pillar positions (p1x/p1y/p2x/p2y), bird top-y and running score, and detects collisions against pillars, ground and ceiling.
// - Debounce-free flap button edge detection; issues per-frame flap pulse to bird physics; tracks best score.
// - Sits between input/pillar/bird stages and the VGA mux; all updates gated by frame_tick.
// PARAMETERS
// BIRD_X     360  left edge of bird box (fixed column)
// BIRD_W     48   bird box width, px
// BIRD_H     48   bird box height, px
// PILLAR_W   144  pillar width; pillar spans [px-PILLAR_W, px]
// GAP_H      260  vertical gap; open region is (py, py+GAP_H)
// GROUND_Y   720  bird bottom >= GROUND_Y is a hit
// DEAD_FRAMES 60  frames in END before a flap may restart
// PORTS
// clk         in   1   pixel/system clock (single clock domain)
// rst         in   1   asynchronous, active-high reset
// frame_tick  in   1   1-cycle strobe, once per video frame
// btn         in   1   raw flap button, asynchronous to clk
// birdy       in   11  bird box top y
// p1x,p1y     in   11  pillar 1 right edge x / gap top y
// p2x,p2y     in   11  pillar 2 right edge x / gap top y
// score       in   14  running score from pillar stage
// state       out  3   one-hot: [0]=READY [1]=PLAYING [2]=END
// flap_pulse  out  1   1-cycle, coincident-next-clk with frame_tick, flap consumed in PLAYING
// hit         out  1   sticky collision flag, set on PLAYING->END, cleared on END->READY
// best_score  out  14  highest score since reset
// BEHAVIOUR
// - Reset (async, rst=1): state=3'b001, flap_pulse=0, hit=0, best_score=0, hold_cnt=0, flap_pend=0, sync regs=0.
// - btn: 2-FF synchroniser then rising-edge detect (3rd FF). Edge sets flap_pend; flap_pend cleared on any frame_tick cycle (consumed or discarded).
// - Edge and frame_tick in same cycle: edge counts as pending for that tick.
// - All state changes occur on the clk edge following a cycle with frame_tick=1; otherwise all regs hold (flap_pulse=0).
// - Collision (combinational, 12-bit arithmetic to avoid wrap):
//   xov(px) = (BIRD_X+BIRD_W >= px-PILLAR_W, clamped at 0) && (BIRD_X <= px)
//   yhit(py) = (birdy <= py) || (birdy+BIRD_H >= py+GAP_H)
//   hit_now = (xov(p1x)&&yhit(p1y)) || (xov(p2x)&&yhit(p2y)) || (birdy+BIRD_H >= GROUND_Y) || (birdy == 0)
// - FSM (on frame_tick):
//   READY:   flap_pend -> PLAYING, flap_pulse=1. Else stay.
//   PLAYING: hit_now -> END, hit=1, hold_cnt=DEAD_FRAMES, best_score=max(best_score,score); flap ignored that tick.
//            else flap_pend -> flap_pulse=1, stay.
//   END:     hold_cnt>0 -> hold_cnt-1, flaps discarded. hold_cnt==0 && flap_pend -> READY, hit=0.
// - best_score compares against score as seen on the transition tick (score frozen by pillar stage in END).
// - Illegal state encoding (not one-hot) -> READY on next clk.
// - rst mid-play: immediate READY; best_score cleared.
// STRUCTURE
// - game_defs.vh: ST_READY/ST_PLAYING/ST_END one-hot localparams, bit indices, geometry defaults shared with pillar/bird stages.
// - Sub-module btn_edge (2-FF sync + rising-edge pulse), reused by other input stages.
// - Remainder: collision comb logic, FSM, hold counter, best-score register.
// TESTING
// - Reset: assert rst mid-PLAYING -> state=001, hit=0, best_score=0, flap_pulse=0 immediately.
// - Start: READY, btn 0->1 held 10 clk, then frame_tick -> next clk state=010, flap_pulse=1 for 1 clk.
// - Pillar hit: PLAYING, p1x=500, p1y=400, birdy=380, frame_tick -> state=100, hit=1.
// - Clear gap: p1x=500, p1y=400, birdy=450 (bottom 498 < 660), p2x=900 -> state stays 010.
// - Ground: birdy=672 (bottom 720) -> END; birdy=671 with no pillar overlap -> stays PLAYING.
// - Best/hold: END entry with score=7, best=3 -> best_score=7; btn within 60 ticks ignored; btn after 60 ticks -> READY, hit=0, best_score stays 7.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared game definitions: one-hot state encoding, playfield geometry and the
// pillar collision test used by the game sequencer.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_READY   = 3'b001,
        ST_PLAYING = 3'b010,
        ST_END     = 3'b100
    } state_t;

    localparam logic [11:0] BIRD_X   = 12'd360;
    localparam logic [11:0] BIRD_W   = 12'd48;
    localparam logic [11:0] BIRD_H   = 12'd48;
    localparam logic [11:0] PILLAR_W = 12'd144;
    localparam logic [11:0] GAP_H    = 12'd260;
    localparam logic [11:0] GROUND_Y = 12'd720;
    localparam logic [5:0]  DEAD_FRAMES = 6'd60;

    // Pillar left edge clamps at 0 so a pillar scrolling off-screen still overlaps.
    function automatic logic pillar_hit(input logic [11:0] by,
                                        input logic [11:0] px,
                                        input logic [11:0] py);
        logic [11:0] left;
        logic        xov;
        logic        yhit;
        left = (px >= PILLAR_W) ? (px - PILLAR_W) : '0;
        xov  = ((BIRD_X + BIRD_W) >= left) && (BIRD_X <= px);
        yhit = (by <= py) || ((by + BIRD_H) >= (py + GAP_H));
        return xov && yhit;
    endfunction

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a third flop
// for rising-edge detection; rise is a 1-cycle pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], btn};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/game_ctrl.sv
// Flappy game sequencer: READY/PLAYING/END state machine advanced once per
// frame, collision detection, flap pulse generation and best-score tracking.
module game_ctrl
    import game_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn,
    input  logic [10:0] birdy,
    input  logic [10:0] p1x,
    input  logic [10:0] p1y,
    input  logic [10:0] p2x,
    input  logic [10:0] p2y,
    input  logic [13:0] score,
    output logic [2:0]  state,
    output logic        flap_pulse,
    output logic        hit,
    output logic [13:0] best_score
);

    state_t      state_q;
    logic        rise;
    logic        flap_pend;
    logic        pend;
    logic [5:0]  hold_cnt;
    logic [11:0] by;
    logic        hit_now;

    btn_edge u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .rise (rise)
    );

    // An edge arriving in the same cycle as frame_tick is honoured by that tick.
    assign pend = flap_pend | rise;

    assign by      = {1'b0, birdy};
    assign hit_now = pillar_hit(by, {1'b0, p1x}, {1'b0, p1y})
                   || pillar_hit(by, {1'b0, p2x}, {1'b0, p2y})
                   || ((by + BIRD_H) >= GROUND_Y)
                   || (by == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_READY;
            flap_pulse <= 1'b0;
            hit        <= 1'b0;
            best_score <= '0;
            hold_cnt   <= '0;
            flap_pend  <= 1'b0;
        end else begin
            flap_pulse <= 1'b0;
            if (frame_tick) begin
                flap_pend <= 1'b0;
            end else if (rise) begin
                flap_pend <= 1'b1;
            end

            case (state_q)
                ST_READY: begin
                    if (frame_tick && pend) begin
                        state_q    <= ST_PLAYING;
                        flap_pulse <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (frame_tick) begin
                        if (hit_now) begin
                            state_q  <= ST_END;
                            hit      <= 1'b1;
                            hold_cnt <= DEAD_FRAMES;
                            if (score > best_score) begin
                                best_score <= score;
                            end
                        end else if (pend) begin
                            flap_pulse <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (frame_tick) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - 6'd1;
                        end else if (pend) begin
                            state_q <= ST_READY;
                            hit     <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    assign state = state_q;

endmodule
